half_to_pixel_pipe: RTL

- Pipelined, parametrised converter from an IEEE-754 style float to an unsigned fixed-point pixel coordinate.
- Sits between the vertex/transform stage and the VGA pixel addressing logic.
- Handles the full number space: sign, zero, subnormal, inf/NaN and overflow, with saturation and optional rounding.
- Streams one conversion per clock under a valid/ready handshake with full backpressure.

---
 rtl/half_to_pixel_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/half_to_pixel_pipe.sv
// rtl/half_to_pixel_pipe.sv - three-stage float to unsigned fixed-point pixel converter
//
// Ports:
//   i_clk    : clock, all state on the rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_valid  : input word valid
//   o_ready  : block can accept i_float this cycle
//   i_float  : sign | exponent | mantissa
//   o_valid  : result valid
//   i_ready  : downstream accepts the result this cycle
//   o_pixel  : unsigned fixed-point result with FRAC_W fraction bits
//   o_sat    : result clamped to max (overflow, inf, NaN)
//   o_neg    : negative non-zero input clamped to 0
module half_to_pixel_pipe #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int OUT_W  = 17,
    parameter int FRAC_W = 0,
    parameter int ROUND  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [EXP_W+MAN_W:0]   i_float,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [OUT_W-1:0]       o_pixel,
    output logic                   o_sat,
    output logic                   o_neg
);

    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    // Left-shift distance of {1,mantissa} relative to the output LSB is exp + SH_OFS.
    localparam int SH_OFS = FRAC_W - MAN_W - BIAS;
    // Wide enough to hold the largest non-overflowing alignment plus the guard bit.
    localparam int G_W    = OUT_W + MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // ---------------------------------------------------------------- handshake
    logic load1, load2, load3;
    logic s1_valid, s2_valid;

    assign load3   = !o_valid  || i_ready;
    assign load2   = !s2_valid || load3;
    assign load1   = !s1_valid || load2;
    assign o_ready = load1;

    // ---------------------------------------------------------------- S1 decode
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_man;
    logic             s1_zero;
    logic             s1_special;

    logic [EXP_W-1:0] in_exp;
    assign in_exp = i_float[EXP_W+MAN_W-1:MAN_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_man     <= '0;
            s1_zero    <= 1'b0;
            s1_special <= 1'b0;
        end else if (load1) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign    <= i_float[EXP_W+MAN_W];
                s1_exp     <= in_exp;
                s1_man     <= i_float[MAN_W-1:0];
                s1_zero    <= (in_exp == '0);
                s1_special <= (in_exp == EXP_ONES);
            end
        end
    end

    // ---------------------------------------------------------------- S2 align
    int             sh;
    logic [G_W-1:0] g;
    logic           ovf_c;

    always_comb begin
        sh = $signed({{(32-EXP_W){1'b0}}, s1_exp}) + SH_OFS;
        // The extra zero at the bottom becomes the guard bit after a right shift.
        g  = {{(G_W-MAN_W-2){1'b0}}, 1'b1, s1_man, 1'b0};
        if (sh >= 0) begin
            g = g << sh;
        end else begin
            g = g >> (-sh);
        end
        // MSB of the significand lands at bit MAN_W+sh; at or above OUT_W it is lost.
        ovf_c = ((sh + MAN_W) >= OUT_W) || (|g[G_W-1:OUT_W+1]);
    end

    logic             s2_sign;
    logic             s2_zero;
    logic             s2_special;
    logic             s2_ovf;
    logic [OUT_W-1:0] s2_val;
    logic             s2_guard;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_zero    <= 1'b0;
            s2_special <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_val     <= '0;
            s2_guard   <= 1'b0;
        end else if (load2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign    <= s1_sign;
                s2_zero    <= s1_zero;
                s2_special <= s1_special;
                s2_ovf     <= ovf_c;
                s2_val     <= g[OUT_W:1];
                s2_guard   <= g[0];
            end
        end
    end

    // ---------------------------------------------------------------- S3 finish
    logic             rnd_bit;
    logic [OUT_W:0]   sum;
    logic             big;
    logic             nonzero;
    logic [OUT_W-1:0] pix_c;
    logic             sat_c;
    logic             neg_c;

    always_comb begin
        rnd_bit = (ROUND != 0) && s2_guard;
        sum     = {1'b0, s2_val} + {{OUT_W{1'b0}}, rnd_bit};
        big     = s2_ovf || sum[OUT_W];
        nonzero = big || (sum[OUT_W-1:0] != '0);
        pix_c   = '0;
        sat_c   = 1'b0;
        neg_c   = 1'b0;
        if (s2_special) begin
            // inf and NaN saturate regardless of sign
            pix_c = '1;
            sat_c = 1'b1;
        end else if (s2_zero) begin
            pix_c = '0;
        end else if (s2_sign) begin
            // negative zero after rounding is not reported as a clamp
            neg_c = nonzero;
        end else if (big) begin
            pix_c = '1;
            sat_c = 1'b1;
        end else begin
            pix_c = sum[OUT_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_pixel <= '0;
            o_sat   <= 1'b0;
            o_neg   <= 1'b0;
        end else if (load3) begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_pixel <= pix_c;
                o_sat   <= sat_c;
                o_neg   <= neg_c;
            end
        end
    end

endmodule
